// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared types and helpers for the tick generator.
//   chan_state_t : per-channel run state (IDLE / RUN)
//   MAX_NCH      : largest supported channel count
//   sel_width()  : width of a channel-select field, never less than 1 bit
//   period_width(): bits needed to hold a given period value
package tick_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chan_state_t;

  localparam int MAX_NCH = 16;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int period_width(input longint p);
    return (p > 1) ? $clog2(p + 1) : 1;
  endfunction

endpackage

// File: rtl/tick_channel.sv
// tick_channel: one independent divider channel.
//   clk, reset        : clock, synchronous active-high reset
//   we                : load cfg_period / cfg_oneshot (already decoded)
//   start, stop       : per-channel strobes (already decoded)
//   cfg_period        : new period in cycles (0 stored as 1)
//   cfg_oneshot       : 1 = one-shot, 0 = periodic
//   tick, level, busy : registered outputs
module tick_channel
  import tick_gen_pkg::*;
#(
  parameter int WIDTH          = 27,
  parameter int DEFAULT_PERIOD = 100_000_000,
  parameter bit AUTO_START     = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_oneshot,
  output logic             tick,
  output logic             level,
  output logic             busy
);

  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);

  chan_state_t      state, state_n;
  logic [WIDTH-1:0] period, period_n;
  logic [WIDTH-1:0] count, count_n;
  logic             oneshot, oneshot_n;
  logic             tick_n, level_n;
  // Set by reset: the first edge after release behaves like a start edge,
  // so an auto-started channel ticks exactly DEFAULT_PERIOD edges after it.
  logic             fresh;
  logic             term;

  assign term = (count == (period - WIDTH'(1)));
  assign busy = (state == RUN);

  always_comb begin
    state_n   = state;
    period_n  = period;
    oneshot_n = oneshot;
    count_n   = count;
    tick_n    = 1'b0;
    level_n   = level;
    if (stop) begin
      state_n = IDLE;
      count_n = '0;
    end else if (start || we) begin
      if (we) begin
        period_n  = (cfg_period == '0) ? WIDTH'(1) : cfg_period;
        oneshot_n = cfg_oneshot;
      end
      if (start) state_n = RUN;
      count_n = '0;
    end else if (fresh || state == IDLE) begin
      count_n = '0;
    end else if (term) begin
      count_n = '0;
      tick_n  = 1'b1;
      level_n = ~level;
      if (oneshot) state_n = IDLE;
    end else begin
      count_n = count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= AUTO_START ? RUN : IDLE;
      period  <= DEF_P;
      oneshot <= 1'b0;
      count   <= '0;
      tick    <= 1'b0;
      level   <= 1'b0;
      fresh   <= 1'b1;
    end else begin
      state   <= state_n;
      period  <= period_n;
      oneshot <= oneshot_n;
      count   <= count_n;
      tick    <= tick_n;
      level   <= level_n;
      fresh   <= 1'b0;
    end
  end

endmodule

// File: rtl/tick_gen.sv
// tick_gen: NCH-channel programmable tick generator.
//   clk, reset        : clock, synchronous active-high reset
//   cfg_we/cfg_ch     : configuration write strobe and target channel
//                       (channel numbers >= NCH are ignored)
//   cfg_period        : period in clk cycles (0 treated as 1)
//   cfg_oneshot       : 1 = one-shot, 0 = periodic
//   start, stop       : per-channel strobes
//   tick, level, busy : per-channel registered outputs
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int WIDTH          = 27,
  parameter int DEFAULT_PERIOD = 100_000_000,
  parameter bit AUTO_START     = 1'b1,
  localparam int CH_W          = sel_width(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_oneshot,
  input  logic [NCH-1:0]   start,
  input  logic [NCH-1:0]   stop,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   level,
  output logic [NCH-1:0]   busy
);

  logic [NCH-1:0] we_vec;

  // One-hot write decode; out-of-range channel numbers match nothing.
  always_comb begin
    we_vec = '0;
    for (int i = 0; i < NCH; i++)
      we_vec[i] = cfg_we && (cfg_ch == CH_W'(i));
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tick_channel #(
      .WIDTH          (WIDTH),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .AUTO_START     (AUTO_START)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .we          (we_vec[i]),
      .start       (start[i]),
      .stop        (stop[i]),
      .cfg_period  (cfg_period),
      .cfg_oneshot (cfg_oneshot),
      .tick        (tick[i]),
      .level       (level[i]),
      .busy        (busy[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: directed + random stimulus against a deadline-based model of
// tick_gen. Each running channel is modelled by the absolute edge number of
// its next tick, not by a counter.
module tb_tick_gen;
  localparam int NCH   = 4;
  localparam int WIDTH = 8;
  localparam int DEFP  = 5;
  localparam bit AS    = 1'b1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_ch = '0;
  logic [WIDTH-1:0] cfg_period = '0;
  logic             cfg_oneshot = 1'b0;
  logic [NCH-1:0]   start = '0;
  logic [NCH-1:0]   stop = '0;
  logic [NCH-1:0]   tick, level, busy;

  int     n_pass = 0, n_fail = 0, n_tot = 0;
  longint edge_n = 0;

  int     m_per  [NCH];
  bit     m_one  [NCH];
  bit     m_run  [NCH];
  bit     m_lvl  [NCH];
  bit     m_tick [NCH];
  longint m_next [NCH];

  tick_gen #(
    .NCH(NCH), .WIDTH(WIDTH), .DEFAULT_PERIOD(DEFP), .AUTO_START(AS)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_oneshot(cfg_oneshot),
    .start(start), .stop(stop), .tick(tick), .level(level), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [NCH-1:0] got, input logic [NCH-1:0] exp);
    n_tot++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s @edge %0d: got %b expected %b", tag, edge_n, got, exp);
    end
  endtask

  // Apply the rules for the inputs sampled at the edge numbered edge_n.
  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit w;
      w = cfg_we && (int'(cfg_ch) == c);
      if (reset) begin
        m_per[c] = DEFP; m_one[c] = 1'b0; m_run[c] = AS;
        m_lvl[c] = 1'b0; m_tick[c] = 1'b0;
        m_next[c] = edge_n + 1 + DEFP;
      end else if (stop[c]) begin
        m_run[c] = 1'b0; m_tick[c] = 1'b0;
      end else if (start[c] || w) begin
        if (w) begin
          m_per[c] = (cfg_period == 0) ? 1 : int'(cfg_period);
          m_one[c] = cfg_oneshot;
        end
        if (start[c]) m_run[c] = 1'b1;
        m_tick[c] = 1'b0;
        m_next[c] = edge_n + m_per[c];
      end else if (m_run[c] && edge_n == m_next[c]) begin
        m_tick[c] = 1'b1;
        m_lvl[c]  = ~m_lvl[c];
        if (m_one[c]) m_run[c] = 1'b0;
        else m_next[c] = edge_n + m_per[c];
      end else begin
        m_tick[c] = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [NCH-1:0] et, el, eb;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < NCH; c++) begin
      et[c] = m_tick[c]; el[c] = m_lvl[c]; eb[c] = m_run[c];
    end
    chk("tick", tick, et);
    chk("level", level, el);
    chk("busy", busy, eb);
    edge_n++;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic cfg(input int ch, input int p, input bit os, input logic [NCH-1:0] st);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_period = WIDTH'(p); cfg_oneshot = os; start = st;
    step();
    cfg_we = 1'b0; start = '0;
  endtask

  initial begin
    // Reset with auto-start
    steps(3);
    chk("rst_busy", busy, 4'hF);
    chk("rst_tick", tick, 4'h0);
    chk("rst_level", level, 4'h0);
    reset = 1'b0;
    steps(5);
    chk("auto_no_early_tick", tick, 4'h0);
    step();
    chk("auto_first_tick", tick, 4'hF);
    chk("auto_first_level", level, 4'hF);
    steps(12);

    // Channel 1 periodic P=4
    cfg(1, 4, 1'b0, 4'b0010);
    steps(12);

    // Channel 2 one-shot P=3
    cfg(2, 3, 1'b1, 4'b0100);
    steps(2);
    step();
    chk("oneshot_tick", NCH'(tick[2]), 4'h1);
    chk("oneshot_busy", NCH'(busy[2]), 4'h0);
    steps(20);

    // Channel 0 P=4, stop on the terminal-count cycle
    cfg(0, 4, 1'b0, '0);
    for (int i = 0; i < 20 && !(m_run[0] && m_next[0] == edge_n); i++) step();
    chk("wait_tc0", NCH'(m_run[0] && m_next[0] == edge_n), 4'h1);
    begin
      logic lv;
      lv = level[0];
      stop = 4'b0001;
      step();
      stop = '0;
      chk("stop_tc_tick", NCH'(tick[0]), 4'h0);
      chk("stop_tc_busy", NCH'(busy[0]), 4'h0);
      chk("stop_tc_level", NCH'(level[0]), NCH'(lv));
    end
    start = 4'b0001; stop = 4'b0001;
    step();
    start = '0; stop = '0;
    chk("start_stop_idle", NCH'(busy[0]), 4'h0);
    steps(6);

    // Channel 3 P=10, shrink to 2 at count 7, then P=0
    cfg(3, 10, 1'b0, 4'b1000);
    for (int i = 0; i < 30 && !(m_next[3] == edge_n + 2); i++) step();
    chk("wait_cnt7", NCH'(m_next[3] == edge_n + 2), 4'h1);
    cfg(3, 2, 1'b0, '0);
    steps(8);
    cfg(3, 0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("p0_tick_every_cycle", NCH'(tick[3]), 4'h1);
    end

    // Reset pulse mid-run
    steps(3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy", busy, 4'hF);
    chk("midrst_tick", tick, 4'h0);
    chk("midrst_level", level, 4'h0);
    steps(12);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      reset       = ($urandom_range(0, 199) == 0);
      cfg_we      = ($urandom_range(0, 7) == 0);
      cfg_ch      = 2'($urandom_range(0, 3));
      cfg_period  = WIDTH'($urandom_range(0, 7));
      cfg_oneshot = 1'($urandom_range(0, 1));
      for (int c = 0; c < NCH; c++) begin
        start[c] = ($urandom_range(0, 15) == 0);
        stop[c]  = ($urandom_range(0, 23) == 0);
      end
      step();
    end
    reset = 1'b0; cfg_we = 1'b0; start = '0; stop = '0;
    steps(4);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/tick_gen.md
# tick_gen

Multi-channel programmable tick generator: each of NCH independent channels divides `clk` by a run-time-programmable period and emits a one-cycle `tick` pulse, a toggling `level` square wave and a `busy` flag. Channels run periodic or one-shot, and each can be started, stopped and reprogrammed individually. It is the shared timebase for game-level timing: display refresh, blink rate, reveal timeout and move timer all hang off one instance.

## Interface
- `NCH`, 4, number of channels (1..16)
- `WIDTH`, 27, period/counter width in bits
- `DEFAULT_PERIOD`, 100_000_000, per-channel period loaded at reset (must fit WIDTH, ≥1)
- `AUTO_START`, 1, when 1 all channels enter RUN (periodic) on reset release; when 0 they stay IDLE
- `clk` in 1: system clock; one clock domain only
- `reset` in 1: synchronous, active-high
- `cfg_we` in 1: write strobe for channel configuration
- `cfg_ch` in $clog2(NCH) (min 1): channel addressed by `cfg_we`; values ≥NCH are ignored
- `cfg_period` in WIDTH: new period P in clk cycles; 0 is stored as 1
- `cfg_oneshot` in 1: 1 = one-shot mode, 0 = periodic
- `start` in NCH: per-channel start/restart strobe
- `stop` in NCH: per-channel stop strobe
- `tick` out NCH: registered one-cycle pulse at each terminal count
- `level` out NCH: registered, toggles on each tick (50% duty when periodic)
- `busy` out NCH: registered, 1 while channel is in RUN

## Operation
- Per-channel state: IDLE, RUN. Per-channel registers: `period`, `oneshot`, `count` (WIDTH bits), `tick`, `level`, state.
- Reset: `period`=DEFAULT_PERIOD, `oneshot`=0, `count`=0, `tick`=0, `level`=0; state = RUN if AUTO_START else IDLE; `busy` = AUTO_START.
- IDLE: `count` held at 0, `tick`=0. `start` → RUN, `count`←0.
- RUN: `count` increments each cycle. When `count`==period−1: `count`←0, `tick`←1, `level`←~`level`; if `oneshot`, state←IDLE. Otherwise `tick`←0.
- `stop` (any state): state←IDLE, `count`←0, `tick`←0; `level` retains its value.
- `start` in RUN: restart, `count`←0, no tick that cycle.
- `cfg_we` to channel c: `period`, `oneshot` updated; `count`←0; state and `level` unchanged. Guarantees no overrun when the period shrinks below the current count.
- Priority per channel in one cycle: `reset` > `stop` > `start`/`cfg_we` > terminal count. `start` and `cfg_we` on the same channel in one cycle: new config applied, channel enters RUN from 0. `stop` coinciding with a terminal count: no tick, no level toggle.
- Channels are fully independent; simultaneous ticks on several channels are allowed.

## Timing
- `start` sampled at edge k → first `tick` high for the cycle after edge k+P; periodic ticks repeat every P cycles exactly (no drift, no extra idle cycle).
- P=1: `tick` held high every cycle while RUN; `level` toggles every cycle.
- One-shot: `busy` falls on the same edge that raises `tick`; exactly one tick per start.
- After AUTO_START reset release (reset low at edge k), first tick follows edge k+DEFAULT_PERIOD.
- All outputs registered; no combinational path from any input to any output.

## Structure
- Package `tick_gen_pkg`: `chan_state_t` enum (IDLE, RUN), `MAX_NCH`=16 constant, period type width helper.
- Sub-module `tick_channel` (one channel: state, counter, tick/level/busy registers, with `we`/`start`/`stop` already decoded to 1 bit); `tick_gen` decodes `cfg_ch` and instantiates NCH copies in a generate loop.

## Test plan
- Reset with AUTO_START=1, DEFAULT_PERIOD=5: all `busy`=1, `tick`=0, `level`=0; ticks follow edges 5, 10, 15 after release, `level` 1,0,1.
- Channel 1 cfg P=4 periodic, start at edge 20 → ticks after edges 24, 28, 32; other channels unaffected.
- Channel 2 cfg P=3 one-shot, start at edge 40 → single tick after edge 43, `busy` 1→0 at edge 43, no further ticks over 20 cycles.
- Channel 0 P=4 running, `stop` asserted on the terminal-count cycle → no tick, `busy`=0, `level` unchanged; `start`+`stop` together → stays IDLE.
- Channel 3 running P=10 at count 7, write P=2 → `count`←0, ticks every 2 cycles afterwards; write P=0 → behaves as P=1 (tick every cycle).
- `reset` pulsed mid-run with count=6 → next cycle all outputs at reset values, periods back to DEFAULT_PERIOD.
